// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, ALU control
// codes, PC/writeback mux selects and the sequencer state type.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from (opcode, funct3, funct7).
// Only funct7[5] matters: it selects sub over add for R-type funct3=000.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] aluctl
);

    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        aluctl = ALU_ADD;
        case (opcode)
            OP_R, OP_I: begin
                case (funct3)
                    3'b000:  aluctl = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b111:  aluctl = ALU_AND;
                    3'b110:  aluctl = ALU_OR;
                    3'b010:  aluctl = ALU_SLT;
                    default: aluctl = ALU_ADD;
                endcase
            end
            OP_BRANCH: aluctl = ALU_SUB;
            default:   aluctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port via mem_req/mem_ready.
// Optional cycle/instret counters are built when MULTICYCLE_PERF_CNT_EN is defined.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       regwrite,
    output logic [1:0] wb_sel,
    output logic       alusrc,
    output logic [3:0] aluctl,
    output logic       instr_done,
    output logic       illegal
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    state_t     state_q, state_d;
    logic [3:0] dec_aluctl;

    alu_decoder u_alu_decoder (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .aluctl (dec_aluctl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: state_d = is_legal_op(opcode) ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                if (opcode == OP_R || opcode == OP_I)           state_d = ST_WB;
                else if (opcode == OP_LOAD || opcode == OP_STORE) state_d = ST_MEM;
                else                                            state_d = ST_FETCH;
            end
            ST_MEM:    if (mem_ready) state_d = (opcode == OP_STORE) ? ST_FETCH : ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_RESET;
        endcase
    end

    // ALU operand/op stay driven through MEM and WB so the address and result stay valid.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_PLUS4;
        regwrite   = 1'b0;
        wb_sel     = WB_ALU;
        alusrc     = 1'b0;
        aluctl     = 4'b0000;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            alusrc = (opcode == OP_I) || (opcode == OP_LOAD) ||
                     (opcode == OP_STORE) || (opcode == OP_JALR);
            aluctl = dec_aluctl;
        end
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            ST_EXEC: begin
                if (opcode == OP_BRANCH) begin
                    pc_we      = 1'b1;
                    pc_sel     = zero ? PC_BRANCH : PC_PLUS4;
                    instr_done = 1'b1;
                end else if (opcode == OP_JAL || opcode == OP_JALR) begin
                    regwrite   = 1'b1;
                    wb_sel     = WB_PC4;
                    pc_we      = 1'b1;
                    pc_sel     = (opcode == OP_JAL) ? PC_BRANCH : PC_JALR;
                    instr_done = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_STORE);
                if (mem_ready && opcode == OP_STORE) begin
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                end
            end
            ST_WB: begin
                regwrite   = 1'b1;
                wb_sel     = (opcode == OP_LOAD) ? WB_MEM : WB_ALU;
                pc_we      = 1'b1;
                instr_done = 1'b1;
            end
            ST_TRAP:  illegal = 1'b1;
            default:  ;
        endcase
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != ST_RESET && state_q != ST_TRAP) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (instr_done) instret_cnt_d = instret_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    // Counter width only matters for the counter build; keep it referenced here.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; covers counters when
// MULTICYCLE_PERF_CNT_EN is defined.
module tb_multicycle_controller;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_we, addr_sel, ir_we, pc_we, regwrite, alusrc, instr_done, illegal;
  logic [1:0] pc_sel, wb_sel;
  logic [3:0] aluctl;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .regwrite(regwrite), .wb_sel(wb_sel), .alusrc(alusrc), .aluctl(aluctl),
    .instr_done(instr_done), .illegal(illegal)
`ifdef MULTICYCLE_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  // {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, regwrite, wb_sel, alusrc, aluctl, instr_done, illegal}
  logic [16:0] outs;
  assign outs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, regwrite, wb_sel,
                 alusrc, aluctl, instr_done, illegal};

  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND_ = 4'b0000, OR_ = 4'b0001, SLT = 4'b0111;

  int n_checks = 0;
  int n_pass = 0;
  int unsigned exp_cyc = 0;
  int unsigned exp_ret = 0;
  logic live_q = 1'b0;
  logic done_q = 1'b0;

  function automatic logic [16:0] ev(input logic mr, mw, as, ir, pw, input logic [1:0] ps,
                                     input logic rw, input logic [1:0] ws, input logic src,
                                     input logic [3:0] ctl, input logic done, ill);
    return {mr, mw, as, ir, pw, ps, rw, ws, src, ctl, done, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic expect_outs(input string tag, input logic [16:0] exp);
    check(tag, {15'b0, outs}, {15'b0, exp});
    done_q = exp[1];
`ifdef MULTICYCLE_PERF_CNT_EN
    check({tag, "_cycle_cnt"}, cycle_cnt, exp_cyc);
    check({tag, "_instret_cnt"}, instret_cnt, exp_ret);
`endif
  endtask

  // One clock edge; live says whether the new cycle counts toward cycle_cnt.
  task automatic cyc(input logic rdy, input logic z, input logic live);
    @(posedge clk);
    if (live_q) exp_cyc++;
    if (done_q) exp_ret++;
    #1;
    mem_ready = rdy;
    zero = z;
    live_q = live;
    done_q = 1'b0;
    #3;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    exp_cyc = 0;
    exp_ret = 0;
    live_q = 1'b0;
    done_q = 1'b0;
    #1;
    expect_outs({tag, "_async"}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    expect_outs({tag, "_idle"}, '0);
  endtask

  task automatic fetch_decode(input string tag, input int waits, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7, input logic dec_rdy);
    for (int i = 0; i <= waits; i++) begin
      cyc(i == waits, 1'b0, 1'b1);
      if (i == 0) begin
        opcode = op;
        funct3 = f3;
        funct7 = f7;
      end
      expect_outs($sformatf("%s_fetch%0d", tag, i), ev(1, 0, 0, i == waits, 0, 2'b00, 0, 2'b00, 0, 4'b0, 0, 0));
    end
    cyc(dec_rdy, 1'b0, 1'b1);
    expect_outs({tag, "_decode"}, '0);
  endtask

  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic src, input logic [3:0] ctl);
    fetch_decode(tag, 0, op, f3, f7, 1'b0);
    cyc(0, 0, 1);
    expect_outs({tag, "_exec"}, ev(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, src, ctl, 0, 0));
    cyc(0, 0, 1);
    expect_outs({tag, "_wb"}, ev(0, 0, 0, 0, 1, 2'b00, 1, 2'b00, src, ctl, 1, 0));
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       src;
    logic [3:0] ctl;
  } alu_vec_t;

  alu_vec_t alu_tbl[10];

  initial begin
    alu_tbl[0] = '{7'b0110011, 3'b000, 7'h00, 1'b0, ADD};
    alu_tbl[1] = '{7'b0110011, 3'b000, 7'h20, 1'b0, SUB};
    alu_tbl[2] = '{7'b0110011, 3'b111, 7'h00, 1'b0, AND_};
    alu_tbl[3] = '{7'b0110011, 3'b110, 7'h00, 1'b0, OR_};
    alu_tbl[4] = '{7'b0110011, 3'b010, 7'h00, 1'b0, SLT};
    alu_tbl[5] = '{7'b0110011, 3'b100, 7'h00, 1'b0, ADD};
    alu_tbl[6] = '{7'b0010011, 3'b000, 7'h20, 1'b1, ADD};
    alu_tbl[7] = '{7'b0010011, 3'b111, 7'h00, 1'b1, AND_};
    alu_tbl[8] = '{7'b0010011, 3'b110, 7'h00, 1'b1, OR_};
    alu_tbl[9] = '{7'b0010011, 3'b010, 7'h00, 1'b1, SLT};

    #2;
    do_reset("por");

    // addi x1,x0,5 with one fetch wait: retires in the fifth cycle.
    fetch_decode("addi", 1, 7'b0010011, 3'b000, 7'h00, 1'b0);
    cyc(0, 0, 1);
    expect_outs("addi_exec", ev(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, ADD, 0, 0));
    cyc(0, 0, 1);
    expect_outs("addi_wb", ev(0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 1, ADD, 1, 0));

    fetch_decode("beq_t", 0, 7'b1100011, 3'b000, 7'h00, 1'b0);
    cyc(0, 1, 1);
    expect_outs("beq_t_exec", ev(0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 0, SUB, 1, 0));
    fetch_decode("beq_nt", 0, 7'b1100011, 3'b000, 7'h00, 1'b0);
    cyc(0, 0, 1);
    expect_outs("beq_nt_exec", ev(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, SUB, 1, 0));

    for (int i = 0; i < 10; i++)
      run_alu($sformatf("alu%0d", i), alu_tbl[i].op, alu_tbl[i].f3, alu_tbl[i].f7,
              alu_tbl[i].src, alu_tbl[i].ctl);

    fetch_decode("lw", 0, 7'b0000011, 3'b010, 7'h00, 1'b0);
    cyc(0, 0, 1);
    expect_outs("lw_exec", ev(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, ADD, 0, 0));
    cyc(1, 0, 1);
    expect_outs("lw_mem", ev(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 1, ADD, 0, 0));
    cyc(0, 0, 1);
    expect_outs("lw_wb", ev(0, 0, 0, 0, 1, 2'b00, 1, 2'b01, 1, ADD, 1, 0));

    // Store with one memory wait: request and strobe hold until ready.
    fetch_decode("sw", 0, 7'b0100011, 3'b010, 7'h00, 1'b0);
    cyc(0, 0, 1);
    expect_outs("sw_exec", ev(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, ADD, 0, 0));
    cyc(0, 0, 1);
    expect_outs("sw_mem_wait", ev(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 1, ADD, 0, 0));
    cyc(1, 0, 1);
    expect_outs("sw_mem_hit", ev(1, 1, 1, 0, 1, 2'b00, 0, 2'b00, 1, ADD, 1, 0));

    // Stray mem_ready in DECODE/EXEC must be ignored.
    fetch_decode("jal", 0, 7'b1101111, 3'b000, 7'h00, 1'b1);
    cyc(1, 0, 1);
    expect_outs("jal_exec", ev(0, 0, 0, 0, 1, 2'b01, 1, 2'b10, 0, ADD, 1, 0));

    fetch_decode("jalr", 0, 7'b1100111, 3'b000, 7'h00, 1'b0);
    cyc(0, 0, 1);
    expect_outs("jalr_exec", ev(0, 0, 0, 0, 1, 2'b10, 1, 2'b10, 1, ADD, 1, 0));

    fetch_decode("ill", 0, 7'b0000000, 3'b000, 7'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(logic'(i % 2), 0, 0);
      expect_outs($sformatf("trap%0d", i), ev(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 4'b0, 0, 1));
    end
    do_reset("trap_rst");

    fetch_decode("resume", 0, 7'b0010011, 3'b000, 7'h00, 1'b0);
    cyc(0, 0, 1);
    expect_outs("resume_exec", ev(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, ADD, 0, 0));
    cyc(0, 0, 1);
    expect_outs("resume_wb", ev(0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 1, ADD, 1, 0));

    // Reset while FETCH is waiting on memory.
    cyc(0, 0, 1);
    expect_outs("fetch_pending", ev(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 4'b0, 0, 0));
    do_reset("fetch_rst");
    cyc(0, 0, 1);
    expect_outs("fetch_after_rst", ev(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 4'b0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencing FSM for the RV32I subset core. Replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB sequence.
- Shares one unified instruction/data memory port through a req/ready handshake.
- Drives PC, IR, register file, ALU and memory enables for the existing datapath.

Parameters:
- CNT_W, 32, width of performance counters (used only with PERF_CNT_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completion, single-cycle pulse per accepted request
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  store strobe, qualified by mem_req
- addr_sel  out  1  memory address: 0=PC, 1=ALU result
- ir_we  out  1  IR load enable
- pc_we  out  1  PC update enable
- pc_sel  out  2  next PC: 00 PC+4, 01 PC+immB/J, 10 (rs1+immI)&~1
- regwrite  out  1  register file write enable
- wb_sel  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4
- alusrc  out  1  ALU operand B: 0=rs2, 1=immediate
- aluctl  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, TRAP. State register is async-cleared to RESET.
- Outputs are combinational from state, opcode, funct3, funct7 and zero.
- In RESET all outputs are 0. RESET moves to FETCH unconditionally on the next cycle.
- FETCH:
  - Drive mem_req=1, addr_sel=0.
  - On mem_ready: ir_we=1, go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - One cycle, no strobes.
  - Recognised opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111.
  - Any recognised opcode goes to EXEC. Any other opcode goes to TRAP.
- EXEC:
  - alusrc=1 for I, LOAD, STORE, JALR; otherwise 0.
  - aluctl: R and I use funct3 (000 add, or sub when R-type and funct7[5]=1; 111 and; 110 or; 010 slt). Other funct3 values decode to add. LOAD, STORE, JALR use add. BRANCH uses sub.
  - R/I: go to WB.
  - LOAD/STORE: go to MEM.
  - BRANCH (BEQ): pc_we=1, pc_sel=01 if zero else 00, instr_done=1, go to FETCH.
  - JAL: regwrite=1, wb_sel=10, pc_we=1, pc_sel=01, instr_done=1, go to FETCH.
  - JALR: same as JAL but pc_sel=10.
- MEM:
  - Drive mem_req=1, addr_sel=1, mem_we=1 for STORE.
  - On mem_ready: STORE does pc_we=1, pc_sel=00, instr_done=1 and goes to FETCH. LOAD goes to WB.
- WB:
  - regwrite=1, wb_sel=01 for LOAD else 00, pc_we=1, pc_sel=00, instr_done=1, go to FETCH.
- TRAP:
  - Absorbing state. illegal=1, all strobes 0. Exit only via rst_n.
- Latency: R/I 4 cycles, BEQ/JAL/JALR 3 cycles, SW 4 cycles, LW 5 cycles, each plus memory wait cycles.
- mem_ready while mem_req=0 is ignored.
- mem_req and mem_we remain stable until mem_ready; no request is withdrawn while pending.
- pc_we, ir_we, regwrite and instr_done assert for exactly one cycle per instruction.
- rst_n asserted mid-instruction: immediate return to RESET. The pending memory request is dropped, illegal is cleared, and the datapath is left untouched.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- When defined, two extra outputs are present:
  - cycle_cnt [CNT_W]: increments every cycle outside RESET.
  - instret_cnt [CNT_W]: increments on instr_done.
- Both counters async-clear on rst_n, wrap modulo 2^CNT_W, and freeze in TRAP.
- When undefined, no counter ports or logic exist.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode localparams
  - aluctl codes
  - pc_sel and wb_sel encodings
  - state typedef
- One sub-module: alu_decoder, combinational mapping of (opcode, funct3, funct7) to aluctl.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready after 1 wait cycle -> FETCH 2 cycles; ir_we, then regwrite=1/wb_sel=00/alusrc=1/aluctl=0010 in WB; instr_done at cycle 5.
- beq with zero=1, then zero=0 -> EXEC shows pc_sel=01, then 00, with pc_we=1 each; 3 cycles each.
- lw then sw, mem_ready immediate -> MEM addr_sel=1; lw WB with wb_sel=01; sw mem_we=1, no regwrite.
- jalr (opcode 1100111) -> EXEC regwrite=1, wb_sel=10, pc_sel=10, alusrc=1.
- Opcode 0000000 -> TRAP; illegal=1 persists 20 cycles with mem_req=0; rst_n pulse clears it and the FSM resumes FETCH.
- rst_n asserted while FETCH awaits mem_ready -> all outputs 0 immediately; with MULTICYCLE_PERF_CNT_EN, both counters read 0.
